// File: rtl/run_ctrl_pkg.sv
// Shared state encoding and default sizing for the program-run controller.
package run_ctrl_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, CORE_RST, RUN, DONE} run_state_t;

    localparam int          AW_DEF      = 8;
    localparam int          DW_DEF      = 8;
    localparam int          CW_DEF      = 16;
    localparam logic [15:0] MAX_CYC_DEF = 16'd4000;
    localparam int          RST_CYC_DEF = 2;
endpackage

// File: rtl/run_ctrl_ld_seq.sv
// Preload sequencer: turns host bytes into registered data-memory writes at
// consecutive (wrapping) addresses and flags the cycle carrying the last write.
module ld_seq
    import run_ctrl_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          cancel,
    input  logic [AW-1:0] base,
    input  logic [AW:0]   len,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_dat,
    output logic          last_wr
);
    logic [AW-1:0] addr;
    logic [AW:0]   remaining;

    always_ff @(posedge clk) begin
        if (!reset) begin
            addr      <= '0;
            remaining <= '0;
            ld_ready  <= 1'b0;
            mem_wr_en <= 1'b0;
            mem_addr  <= '0;
            mem_dat   <= '0;
            last_wr   <= 1'b0;
        end else if (cancel) begin
            remaining <= '0;
            ld_ready  <= 1'b0;
            mem_wr_en <= 1'b0;
            last_wr   <= 1'b0;
        end else if (start) begin
            addr      <= base;
            remaining <= len;
            ld_ready  <= (len != '0);
            mem_wr_en <= 1'b0;
            last_wr   <= 1'b0;
        end else begin
            mem_wr_en <= 1'b0;
            last_wr   <= 1'b0;
            // Address wraps naturally in AW bits (255 -> 0).
            if (ld_valid && ld_ready) begin
                mem_wr_en <= 1'b1;
                mem_addr  <= addr;
                mem_dat   <= ld_data;
                addr      <= addr + 1'b1;
                remaining <= remaining - 1'b1;
                if (remaining == {{AW{1'b0}}, 1'b1}) begin
                    ld_ready <= 1'b0;
                    last_wr  <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/run_ctrl.sv
// Program-run sequencer: preload data memory, pulse core reset, run the core
// until done or budget expiry, then hold a 4-phase acknowledge.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int          AW      = AW_DEF,
    parameter int          DW      = DW_DEF,
    parameter int          CW      = CW_DEF,
    parameter logic [CW-1:0] MAX_CYC = MAX_CYC_DEF,
    parameter int          RST_CYC = RST_CYC_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    output logic          ack,
    output logic          busy,
    input  logic          abort,
    input  logic [AW-1:0] load_base,
    input  logic [AW:0]   load_len,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    output logic          mem_sel,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_dat,
    output logic          core_reset,
    input  logic          core_done,
    output logic [CW-1:0] cycle_cnt,
    output logic          timed_out
);
    localparam int RW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    run_state_t    state;
    logic [RW-1:0] rst_cnt;
    logic          start;
    logic          cancel;
    logic          last_wr;

    assign start  = (state == IDLE) && req && !ack;
    assign cancel = abort && ((state == LOAD) || (state == CORE_RST) || (state == RUN));

    ld_seq #(.AW(AW), .DW(DW)) u_ld_seq (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .cancel    (cancel),
        .base      (load_base),
        .len       (load_len),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .mem_wr_en (mem_wr_en),
        .mem_addr  (mem_addr),
        .mem_dat   (mem_dat),
        .last_wr   (last_wr)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            rst_cnt    <= '0;
            core_reset <= 1'b1;
            ack        <= 1'b0;
            busy       <= 1'b0;
            mem_sel    <= 1'b0;
            cycle_cnt  <= '0;
            timed_out  <= 1'b0;
        end else if (cancel) begin
            state      <= IDLE;
            core_reset <= 1'b1;
            ack        <= 1'b0;
            busy       <= 1'b0;
            mem_sel    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cycle_cnt <= '0;
                        timed_out <= 1'b0;
                        busy      <= 1'b1;
                        rst_cnt   <= '0;
                        if (load_len != '0) begin
                            state   <= LOAD;
                            mem_sel <= 1'b1;
                        end else begin
                            state <= CORE_RST;
                        end
                    end
                end
                // Leave only once the final write cycle has been presented.
                LOAD: begin
                    if (last_wr) begin
                        state   <= CORE_RST;
                        mem_sel <= 1'b0;
                        rst_cnt <= '0;
                    end
                end
                CORE_RST: begin
                    if (rst_cnt == RW'(RST_CYC - 1)) begin
                        state      <= RUN;
                        core_reset <= 1'b0;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                // core_done takes priority over the budget on the same edge.
                RUN: begin
                    cycle_cnt <= cycle_cnt + 1'b1;
                    if (core_done) begin
                        state      <= DONE;
                        core_reset <= 1'b1;
                        ack        <= 1'b1;
                        timed_out  <= 1'b0;
                    end else if (cycle_cnt == MAX_CYC - 1'b1) begin
                        state      <= DONE;
                        core_reset <= 1'b1;
                        ack        <= 1'b1;
                        timed_out  <= 1'b1;
                    end
                end
                DONE: begin
                    if (!req) begin
                        state <= IDLE;
                        ack   <= 1'b0;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_run_ctrl.sv
// Randomized and directed bench for run_ctrl against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_run_ctrl;
    localparam int AW   = 8;
    localparam int DW   = 8;
    localparam int CW   = 16;
    localparam int MAXC = 20;
    localparam int RSTC = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req = 1'b0;
    logic          abort = 1'b0;
    logic          ld_valid = 1'b0;
    logic          core_done = 1'b0;
    logic [AW-1:0] load_base = '0;
    logic [AW:0]   load_len = '0;
    logic [DW-1:0] ld_data = '0;
    logic          ack, busy, ld_ready, mem_sel, mem_wr_en, core_reset, timed_out;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_dat;
    logic [CW-1:0] cycle_cnt;

    always #5 clk = ~clk;

    run_ctrl #(.AW(AW), .DW(DW), .CW(CW), .MAX_CYC(16'd20), .RST_CYC(RSTC)) dut (
        .clk(clk), .reset(reset), .req(req), .ack(ack), .busy(busy), .abort(abort),
        .load_base(load_base), .load_len(load_len), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_ready(ld_ready), .mem_sel(mem_sel), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_dat(mem_dat), .core_reset(core_reset), .core_done(core_done),
        .cycle_cnt(cycle_cnt), .timed_out(timed_out)
    );

    int checks = 0;
    int errors = 0;
    logic [15:0] wlog[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: phase plus beat/cycle counts, stepped on each posedge.
    typedef enum {P_IDLE, P_LOAD, P_CRST, P_RUN, P_DONE} ph_t;
    ph_t ph = P_IDLE;
    int  m_len = 0, m_base = 0, beats = 0, rst_n = 0, runs = 0, m_addr = 0, m_dat = 0;
    bit  m_tmo = 0, m_wr = 0, was_wr = 0, cnt_known = 1, started = 0;

    always @(posedge clk) begin
        was_wr  = m_wr;
        m_wr    = 0;
        started = 1;
        if (!reset) begin
            ph = P_IDLE; runs = 0; m_tmo = 0; cnt_known = 1;
        end else if (abort && (ph == P_LOAD || ph == P_CRST || ph == P_RUN)) begin
            ph = P_IDLE; cnt_known = 0;
        end else begin
            case (ph)
                P_IDLE: if (req) begin
                    m_base = int'(load_base); m_len = int'(load_len);
                    beats = 0; runs = 0; m_tmo = 0; cnt_known = 1; rst_n = 0;
                    ph = (m_len != 0) ? P_LOAD : P_CRST;
                end
                P_LOAD: begin
                    if (was_wr && beats == m_len) begin
                        ph = P_CRST; rst_n = 0;
                    end else if (ld_valid && beats < m_len) begin
                        m_wr = 1;
                        m_addr = (m_base + beats) % 256;
                        m_dat = int'(ld_data);
                        beats++;
                    end
                end
                P_CRST: begin
                    rst_n++;
                    if (rst_n == RSTC) ph = P_RUN;
                end
                P_RUN: begin
                    runs++;
                    if (core_done) begin ph = P_DONE; m_tmo = 0; end
                    else if (runs == MAXC) begin ph = P_DONE; m_tmo = 1; end
                end
                P_DONE: if (!req) ph = P_IDLE;
                default: ph = P_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("busy", busy, ph != P_IDLE);
            chk("ack", ack, ph == P_DONE);
            chk("core_reset", core_reset, ph != P_RUN);
            chk("mem_sel", mem_sel, ph == P_LOAD);
            chk("ld_ready", ld_ready, (ph == P_LOAD) && (beats < m_len));
            chk("mem_wr_en", mem_wr_en, m_wr);
            if (m_wr) begin
                chk("mem_addr", mem_addr, m_addr);
                chk("mem_dat", mem_dat, m_dat);
            end
            if (cnt_known) begin
                chk("cycle_cnt", cycle_cnt, runs);
                chk("timed_out", timed_out, m_tmo);
            end
        end
        if (mem_wr_en === 1'b1) wlog.push_back({mem_addr, mem_dat});
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_run_start();
        for (int i = 0; i < 30 && core_reset !== 1'b0; i++) tick();
        chk("run_start", core_reset, 0);
    endtask

    initial begin
        reset = 1'b0;
        tick(); tick();
        chk("rst_core_reset", core_reset, 1); chk("rst_ack", ack, 0);
        chk("rst_busy", busy, 0);             chk("rst_ld_ready", ld_ready, 0);
        chk("rst_mem_sel", mem_sel, 0);       chk("rst_wr_en", mem_wr_en, 0);
        chk("rst_addr", mem_addr, 0);         chk("rst_dat", mem_dat, 0);
        chk("rst_cnt", cycle_cnt, 0);         chk("rst_tmo", timed_out, 0);
        reset = 1'b1;

        // Basic run with address wrap.
        wlog.delete();
        req = 1; load_base = 8'hFE; load_len = 3; tick();
        ld_valid = 1; ld_data = 8'hAA; tick();
        ld_data = 8'hBB; tick();
        ld_data = 8'hCC; tick();
        ld_valid = 0;
        wait_run_start();
        repeat (4) tick();
        core_done = 1; tick(); core_done = 0;
        chk("basic_ack", ack, 1); chk("basic_cnt", cycle_cnt, 5); chk("basic_tmo", timed_out, 0);
        chk("basic_nwr", wlog.size(), 3);
        if (wlog.size() == 3) begin
            chk("basic_w0", wlog[0], 16'hFEAA);
            chk("basic_w1", wlog[1], 16'hFFBB);
            chk("basic_w2", wlog[2], 16'h00CC);
        end

        // Handshake: held req keeps ack, no restart.
        repeat (3) tick();
        chk("hold_ack", ack, 1); chk("hold_busy", busy, 1);
        req = 0; tick();
        chk("ack_fall", ack, 0);

        // Empty preload followed by timeout.
        req = 1; load_len = 0; tick();
        chk("empty_busy", busy, 1); chk("empty_sel", mem_sel, 0); chk("empty_cnt", cycle_cnt, 0);
        tick(); chk("empty_cr1", core_reset, 1);
        tick(); chk("empty_cr0", core_reset, 0);
        for (int i = 0; i < 40 && ack !== 1'b1; i++) tick();
        chk("tmo_ack", ack, 1); chk("tmo_cnt", cycle_cnt, 20); chk("tmo_flag", timed_out, 1);
        req = 0; tick();

        // core_done on the budget cycle wins.
        req = 1; load_len = 0; tick();
        wait_run_start();
        repeat (19) tick();
        core_done = 1; tick(); core_done = 0;
        chk("tie_ack", ack, 1); chk("tie_cnt", cycle_cnt, 20); chk("tie_tmo", timed_out, 0);
        req = 0; tick();

        // Stalled preload: valid 1,0,1.
        wlog.delete();
        req = 1; load_base = 8'h10; load_len = 2; tick();
        ld_valid = 1; ld_data = 8'h11; tick();
        ld_valid = 0; tick();
        chk("stall_gap", mem_wr_en, 0);
        ld_valid = 1; ld_data = 8'h22; tick();
        ld_valid = 0; req = 0;
        wait_run_start();
        core_done = 1; tick(); core_done = 0;
        chk("stall_ack", ack, 1);
        chk("stall_nwr", wlog.size(), 2);
        if (wlog.size() == 2) begin
            chk("stall_w0", wlog[0], 16'h1011);
            chk("stall_w1", wlog[1], 16'h1122);
        end
        tick();

        // Abort after one of four beats, then a fresh run.
        wlog.delete();
        req = 1; load_base = 8'h40; load_len = 4; tick();
        ld_valid = 1; ld_data = 8'h5A; tick();
        ld_data = 8'h5B; abort = 1; req = 0; tick();
        abort = 0; ld_valid = 0;
        chk("abort_busy", busy, 0); chk("abort_sel", mem_sel, 0); chk("abort_wr", mem_wr_en, 0);
        chk("abort_ack", ack, 0);   chk("abort_cr", core_reset, 1);
        repeat (3) tick();
        chk("abort_nwr", wlog.size(), 1);
        req = 1; load_base = 8'h80; load_len = 1; ld_valid = 1; ld_data = 8'h77; tick();
        tick(); ld_valid = 0;
        wait_run_start();
        core_done = 1; tick(); core_done = 0;
        chk("fresh_ack", ack, 1); chk("fresh_cnt", cycle_cnt, 1);
        chk("fresh_wlast", wlog[$], 16'h8077);
        req = 0; tick();

        // Reset mid-run at RUN cycle 10.
        req = 1; load_len = 0; tick();
        wait_run_start();
        repeat (9) tick();
        reset = 0; req = 0; tick(); reset = 1;
        chk("mid_cr", core_reset, 1); chk("mid_ack", ack, 0);
        chk("mid_cnt", cycle_cnt, 0); chk("mid_busy", busy, 0);

        // Randomized traffic.
        for (int c = 0; c < 5000; c++) begin
            reset     = ($urandom_range(0, 499) != 0);
            req       = ($urandom_range(0, 5) != 0);
            abort     = ($urandom_range(0, 79) == 0);
            core_done = ($urandom_range(0, 11) == 0);
            ld_valid  = ($urandom_range(0, 2) != 0);
            ld_data   = DW'($urandom);
            load_base = AW'($urandom);
            load_len  = ($urandom_range(0, 19) == 0) ? (AW+1)'($urandom_range(0, 256))
                                                     : (AW+1)'($urandom_range(0, 6));
            tick();
        end
        reset = 1; req = 0; abort = 0; core_done = 0; ld_valid = 0;
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
